mission_sequencer: RTL and testbench

Sequences one warehouse retrieval/storage mission for the line-following cart. It takes a storage command byte (103–105, 107–109, 111–113) and position-tag bytes (1–16) from the UART receivers. It then drives a 2-bit drive-mode command into the motor/line-follow datapath: follow line, turn left, or stop. It sits between the two UART receivers and the motor-drive logic, and replaces ad-hoc per-slot counters with one state machine and shared timers.

---
 rtl/mission_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mission_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mission_sequencer.sv
// mission_sequencer: one warehouse mission FSM with a shared down-timer.
// Ports: clk, rst_n, cmd_valid/cmd_code, pos_valid/pos_code -> drive_mode, busy, done, err, target, state.
module mission_sequencer #(
  parameter int unsigned TURN_CYCLES  = 50_000_000,
  parameter int unsigned DWELL_CYCLES = 250_000_000,
  parameter int unsigned CNT_W        = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_code,
  input  logic       pos_valid,
  input  logic [7:0] pos_code,
  output logic [1:0] drive_mode,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] target,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TO_AISLE = 3'd1,
    S_TURN     = 3'd2,
    S_TO_SLOT  = 3'd3,
    S_DWELL    = 3'd4,
    S_RETURN   = 3'd5
  } state_e;

  localparam logic [1:0] DM_STOP = 2'b00;
  localparam logic [1:0] DM_LINE = 2'b01;
  localparam logic [1:0] DM_LEFT = 2'b10;

  localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [7:0]       HOME_TAG = 8'd16;

  // Aisle marker for a storage code; 0 marks an invalid code.
  function automatic logic [7:0] aisle_of(input logic [7:0] c);
    logic [7:0] a;
    a = 8'd0;
    unique case (1'b1)
      (c >= 8'd103 && c <= 8'd105): a = 8'd15;
      (c >= 8'd107 && c <= 8'd109): a = 8'd6;
      (c >= 8'd111 && c <= 8'd113): a = 8'd10;
      default:                      a = 8'd0;
    endcase
    return a;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       target_q, target_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       dm_q, dm_d;

  logic [7:0] tgt_aisle;
  logic [7:0] tgt_slot;
  logic       cmd_abort;
  logic       cmd_other;
  logic       cmd_ok;

  assign tgt_aisle = aisle_of(target_q);
  assign tgt_slot  = target_q - 8'd100;
  assign cmd_abort = cmd_valid && (cmd_code == 8'd0);
  assign cmd_other = cmd_valid && (cmd_code != 8'd0);
  assign cmd_ok    = aisle_of(cmd_code) != 8'd0;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      target_q <= 8'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dm_q     <= DM_STOP;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      target_q <= target_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dm_q     <= dm_d;
    end
  end

  // Next-state logic; the command is evaluated before any position tag.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    target_d = target_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (state_q == S_IDLE) begin
      if (cmd_other) begin
        if (cmd_ok) begin
          state_d  = S_TO_AISLE;
          target_d = cmd_code;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (cmd_abort) begin
      state_d  = S_IDLE;
      target_d = 8'd0;
      timer_d  = '0;
    end else begin
      // A busy command is rejected but the mission still advances.
      err_d = cmd_other;
      unique case (state_q)
        S_TO_AISLE: begin
          if (pos_valid && pos_code == tgt_aisle) begin
            state_d = S_TURN;
            timer_d = TURN_LD;
          end
        end
        S_TURN: begin
          if (timer_q == '0) state_d = S_TO_SLOT;
          else               timer_d = timer_q - 1'b1;
        end
        S_TO_SLOT: begin
          if (pos_valid && pos_code == tgt_slot) begin
            state_d = S_DWELL;
            timer_d = DWELL_LD;
          end
        end
        S_DWELL: begin
          if (timer_q == '0) state_d = S_RETURN;
          else               timer_d = timer_q - 1'b1;
        end
        S_RETURN: begin
          if (pos_valid && pos_code == HOME_TAG) begin
            state_d  = S_IDLE;
            target_d = 8'd0;
            done_d   = 1'b1;
          end
        end
        default: begin
          state_d  = S_IDLE;
          target_d = 8'd0;
          timer_d  = '0;
        end
      endcase
    end
  end

  // Drive mode follows the next state so it lands with the state register.
  always_comb begin
    dm_d = DM_STOP;
    unique case (state_d)
      S_TO_AISLE: dm_d = DM_LINE;
      S_TURN:     dm_d = DM_LEFT;
      S_TO_SLOT:  dm_d = DM_LINE;
      S_RETURN:   dm_d = DM_LINE;
      default:    dm_d = DM_STOP;
    endcase
  end

  assign drive_mode = dm_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign target     = target_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mission_sequencer.sv
// tb_mission_sequencer: directed checks of mission_sequencer.
// Runs with TURN_CYCLES=4, DWELL_CYCLES=8.
module tb_mission_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       pos_valid;
  logic [7:0] pos_code;
  logic [1:0] drive_mode;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] target;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  mission_sequencer #(
    .TURN_CYCLES(4),
    .DWELL_CYCLES(8),
    .CNT_W(30)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .pos_valid(pos_valid),
    .pos_code(pos_code),
    .drive_mode(drive_mode),
    .busy(busy),
    .done(done),
    .err(err),
    .target(target),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic cv, input logic [7:0] cc,
                        input logic pv, input logic [7:0] pc);
    cmd_valid = cv;
    cmd_code  = cc;
    pos_valid = pv;
    pos_code  = pc;
    step();
    cmd_valid = 1'b0;
    cmd_code  = 8'd0;
    pos_valid = 1'b0;
    pos_code  = 8'd0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".dm"}, 32'(drive_mode), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".err"}, 32'(err), 0);
    chk({tag, ".target"}, 32'(target), 0);
    chk({tag, ".state"}, 32'(state), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_code  = 8'd0;
    pos_valid = 1'b0;
    pos_code  = 8'd0;
    step();
    step();
    chk_idle("reset");
    rst_n = 1'b1;
    step();

    // 1: full mission 104
    strobe(1, 8'd104, 0, 8'd0);
    chk("t1.state", 32'(state), 1);
    chk("t1.busy", 32'(busy), 1);
    chk("t1.target", 32'(target), 104);
    chk("t1.dm", 32'(drive_mode), 1);
    strobe(0, 8'd0, 1, 8'd15);
    for (int i = 0; i < 4; i++) begin
      chk("t1.left", 32'(drive_mode), 2);
      chk("t1.turn", 32'(state), 2);
      step();
    end
    chk("t1.after_turn_dm", 32'(drive_mode), 1);
    chk("t1.after_turn_st", 32'(state), 3);
    strobe(0, 8'd0, 1, 8'd4);
    for (int i = 0; i < 8; i++) begin
      chk("t1.stop", 32'(drive_mode), 0);
      chk("t1.dwell", 32'(state), 4);
      step();
    end
    chk("t1.ret_dm", 32'(drive_mode), 1);
    chk("t1.ret_st", 32'(state), 5);
    strobe(0, 8'd0, 1, 8'd16);
    chk("t1.done", 32'(done), 1);
    chk("t1.end_st", 32'(state), 0);
    chk("t1.end_tgt", 32'(target), 0);
    chk("t1.end_dm", 32'(drive_mode), 0);
    step();
    chk("t1.done_off", 32'(done), 0);

    // 2: wrong-tag filtering, cmd 109
    strobe(1, 8'd109, 0, 8'd0);
    strobe(0, 8'd0, 1, 8'd15);
    chk("t2.p15", 32'(state), 1);
    strobe(0, 8'd0, 1, 8'd3);
    chk("t2.p3", 32'(state), 1);
    strobe(0, 8'd0, 1, 8'd7);
    chk("t2.p7", 32'(state), 1);
    strobe(0, 8'd0, 1, 8'd6);
    chk("t2.p6", 32'(state), 2);
    strobe(0, 8'd0, 1, 8'd9);
    chk("t2.tag_in_turn", 32'(state), 2);
    step();
    step();
    step();
    chk("t2.to_slot", 32'(state), 3);
    strobe(0, 8'd0, 1, 8'd8);
    chk("t2.p8", 32'(state), 3);
    strobe(0, 8'd0, 1, 8'd0);
    chk("t2.p0", 32'(state), 3);
    strobe(0, 8'd0, 1, 8'd9);
    chk("t2.p9", 32'(state), 4);
    strobe(1, 8'd0, 0, 8'd0);
    chk("t2.abort", 32'(state), 0);

    // 3: invalid commands in IDLE
    strobe(1, 8'd106, 0, 8'd0);
    chk("t3.err", 32'(err), 1);
    chk("t3.busy", 32'(busy), 0);
    step();
    chk("t3.err_off", 32'(err), 0);
    strobe(1, 8'd0, 0, 8'd0);
    chk("t3.zero_err", 32'(err), 0);
    chk("t3.zero_busy", 32'(busy), 0);

    // 4: abort during DWELL of 112
    strobe(1, 8'd112, 0, 8'd0);
    strobe(0, 8'd0, 1, 8'd10);
    repeat (4) step();
    chk("t4.to_slot", 32'(state), 3);
    strobe(0, 8'd0, 1, 8'd12);
    chk("t4.dwell", 32'(state), 4);
    step();
    step();
    strobe(1, 8'd0, 0, 8'd0);
    chk_idle("t4.abort");
    step();
    chk("t4.no_done", 32'(done), 0);
    strobe(1, 8'd103, 0, 8'd0);
    chk("t4.restart_st", 32'(state), 1);
    chk("t4.restart_tgt", 32'(target), 103);
    strobe(1, 8'd0, 0, 8'd0);

    // 5: same-cycle strobes, mission 113
    strobe(1, 8'd113, 0, 8'd0);
    strobe(1, 8'd105, 1, 8'd10);
    chk("t5.err", 32'(err), 1);
    chk("t5.turn", 32'(state), 2);
    chk("t5.tgt", 32'(target), 113);
    strobe(1, 8'd0, 0, 8'd0);
    strobe(1, 8'd113, 0, 8'd0);
    chk("t5.re_st", 32'(state), 1);
    strobe(1, 8'd0, 1, 8'd10);
    chk("t5.abort_st", 32'(state), 0);
    chk("t5.abort_tgt", 32'(target), 0);
    chk("t5.abort_err", 32'(err), 0);

    // 6: async reset during TURN, then mission 111
    strobe(1, 8'd111, 0, 8'd0);
    strobe(0, 8'd0, 1, 8'd10);
    chk("t6.turn", 32'(state), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("t6.rst");
    step();
    rst_n = 1'b1;
    step();
    strobe(1, 8'd111, 0, 8'd0);
    chk("t6.st1", 32'(state), 1);
    strobe(0, 8'd0, 1, 8'd10);
    chk("t6.st2", 32'(state), 2);
    repeat (4) step();
    chk("t6.st3", 32'(state), 3);
    strobe(0, 8'd0, 1, 8'd11);
    chk("t6.st4", 32'(state), 4);
    repeat (8) step();
    chk("t6.st5", 32'(state), 5);
    strobe(0, 8'd0, 1, 8'd16);
    chk("t6.done", 32'(done), 1);
    chk("t6.end_st", 32'(state), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
